// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM with memory-wait timeout and sticky fault flags.
// Optional CSR writeback state enabled by defining MC_CSR_EN.
module mc_controller #(
  parameter int ALUC_W      = 4,
  parameter int FULL_BRANCH = 1,
  parameter int WAIT_MAX    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              Zero,
  input  logic              LtS,
  input  logic              LtU,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              illegal_instr,
  output logic              mem_fault
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_SYS      = 4'd13;
  localparam logic [3:0] S_HALT     = 4'd14;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;

  logic [3:0]    state, next;
  logic [CW-1:0] cnt;
  logic          ill_q, flt_q;
  logic          memst, timeout, set_ill, taken;
  logic [3:0]    alu4;

  function automatic logic [3:0] alu_dec(logic [2:0] f3, logic sub_en, logic sra_en);
    case (f3)
      3'b000:  return sub_en ? A_SUB : A_ADD;
      3'b001:  return A_SLL;
      3'b010:  return A_SLT;
      3'b011:  return A_SLTU;
      3'b100:  return A_XOR;
      3'b101:  return sra_en ? A_SRA : A_SRL;
      3'b110:  return A_OR;
      default: return A_AND;
    endcase
  endfunction

  assign illegal_instr = ill_q;
  assign mem_fault     = flt_q;
  assign ALUControl    = ALUC_W'(alu4);

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // Timeout only counts cycles a memory access is outstanding.
  assign memst   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = memst && !mem_ready && (cnt == CNT_LAST);

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = LtS;
      3'b101:  taken = !LtS;
      3'b110:  taken = LtU;
      3'b111:  taken = !LtU;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next = state; set_ill = 1'b0; alu4 = A_ADD;
    mem_req = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    PCWrite = 1'b0; RegWrite = 1'b0; ResultSrc = 2'b00;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1; ALUSrcB = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1; PCWrite = 1'b1; next = S_DECODE;
        end else if (timeout) next = S_HALT;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: next = S_MEMADR;
          7'b0110011:             next = S_EXECR;
          7'b0010011:             next = S_EXECI;
          7'b1100011:             next = S_BRANCH;
          7'b1101111:             next = S_JAL;
          7'b1100111:             next = S_JALR;
          7'b0110111, 7'b0010111: next = S_LUI;
`ifdef MC_CSR_EN
          7'b1110011:             next = S_SYS;
`endif
          default: begin next = S_HALT; set_ill = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1; AdrSrc = 1'b1;
        if (mem_ready) next = S_MEMWB;
        else if (timeout) next = S_HALT;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = 1'b1; next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Drop the write strobe in the cycle the access is abandoned.
        mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = !timeout;
        if (mem_ready) next = S_FETCH;
        else if (timeout) next = S_HALT;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu4 = alu_dec(funct3, funct7b5 & op[5], funct7b5 & op[5]);
        next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        alu4 = alu_dec(funct3, 1'b0, funct7b5);
        next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1; next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu4 = funct3[2] ? (funct3[1] ? A_SLTU : A_SLT) : A_SUB;
        if (FULL_BRANCH == 0 && funct3 != 3'b000) begin
          next = S_HALT; set_ill = 1'b1;
        end else begin
          PCWrite = taken; next = S_FETCH;
        end
      end
      S_JAL: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; PCWrite = 1'b1; next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01; ALUSrcB = 2'b01; next = S_ALUWB;
      end
      S_SYS: begin
`ifdef MC_CSR_EN
        ResultSrc = 2'b10; RegWrite = 1'b1; next = S_FETCH;
`else
        next = S_HALT; set_ill = 1'b1;
`endif
      end
      S_HALT:  next = S_HALT;
      default: next = S_HALT;
    endcase
    if (reset) begin
      mem_req = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      PCWrite = 1'b0; RegWrite = 1'b0; ResultSrc = 2'b00;
      ALUSrcA = 2'b00; ALUSrcB = 2'b00; alu4 = A_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      state <= next;
      if (set_ill) ill_q <= 1'b1;
      if (timeout) flt_q <= 1'b1;
      cnt <= (memst && !mem_ready && !timeout) ? cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: per-cycle vectors flow through a scoreboard
// queue and are compared on the falling edge; a FULL_BRANCH=0 instance is also checked.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, LtS, LtU, mem_ready;

  logic mreq_a, adr_a, mw_a, irw_a, pcw_a, rw_a, ill_a, flt_a;
  logic [1:0] rs_a, sa_a, sb_a;
  logic [2:0] imm_a;
  logic [3:0] alu_a;
  logic mreq_b, adr_b, mw_b, irw_b, pcw_b, rw_b, ill_b, flt_b;
  logic [1:0] rs_b, sa_b, sb_b;
  logic [2:0] imm_b;
  logic [3:0] alu_b;

  always #5 clk = ~clk;

  mc_controller dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LtS(LtS), .LtU(LtU), .mem_ready(mem_ready),
    .mem_req(mreq_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
    .PCWrite(pcw_a), .RegWrite(rw_a), .ResultSrc(rs_a), .ALUSrcA(sa_a),
    .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(alu_a),
    .illegal_instr(ill_a), .mem_fault(flt_a));

  mc_controller #(.FULL_BRANCH(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LtS(LtS), .LtU(LtU), .mem_ready(mem_ready),
    .mem_req(mreq_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .PCWrite(pcw_b), .RegWrite(rw_b), .ResultSrc(rs_b), .ALUSrcA(sa_b),
    .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(alu_b),
    .illegal_instr(ill_b), .mem_fault(flt_b));

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_XOR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_SRL = 4'd8, A_SRA = 4'd9;

  typedef struct packed {
    logic mreq, adr, mw, irw, pcw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic ill, flt;
  } outs_t;

  typedef struct {
    string nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, lts, ltu, rdy, rst;
    outs_t e;
    bit c2;
    outs_t e2;
  } vec_t;

  outs_t oa, ob;
  assign oa = {mreq_a, adr_a, mw_a, irw_a, pcw_a, rw_a, rs_a, sa_a, sb_a, imm_a, alu_a, ill_a, flt_a};
  assign ob = {mreq_b, adr_b, mw_b, irw_b, pcw_b, rw_b, rs_b, sa_b, sb_b, imm_b, alu_b, ill_b, flt_b};

  vec_t tbl[$];
  vec_t sbq[$];
  vec_t mv;
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic c_f7, c_z, c_lts, c_ltu;
  logic s_ill, s_flt;
  int checks = 0, passes = 0;

  function automatic logic [2:0] imm_of(logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic outs_t ex(logic mreq, adr, mw, irw, pcw, rw,
                               logic [1:0] rs, sa, sb, logic [3:0] alu);
    outs_t r;
    r.mreq = mreq; r.adr = adr; r.mw = mw; r.irw = irw; r.pcw = pcw; r.rw = rw;
    r.rs = rs; r.sa = sa; r.sb = sb; r.imm = imm_of(c_op); r.alu = alu;
    r.ill = s_ill; r.flt = s_flt;
    return r;
  endfunction

  function automatic outs_t zr();  return ex(0,0,0,0,0,0,0,0,0,A_ADD); endfunction
  function automatic outs_t ftch(logic rdy); return ex(1,0,0,rdy,rdy,0,0,0,2,A_ADD); endfunction
  function automatic outs_t dec(); return ex(0,0,0,0,0,0,0,1,1,A_ADD); endfunction

  task automatic set_i(logic [6:0] o, logic [2:0] f3, logic f7);
    c_op = o; c_f3 = f3; c_f7 = f7; c_z = 0; c_lts = 0; c_ltu = 0;
  endtask

  task automatic push(string nm, logic rdy, logic rst, outs_t e, bit c2, outs_t e2);
    vec_t v;
    v.nm = nm; v.op = c_op; v.f3 = c_f3; v.f7 = c_f7; v.z = c_z; v.lts = c_lts;
    v.ltu = c_ltu; v.rdy = rdy; v.rst = rst; v.e = e; v.c2 = c2; v.e2 = e2;
    tbl.push_back(v);
  endtask

  task automatic add(string nm, logic rdy, outs_t e); push(nm, rdy, 1'b0, e, 1'b0, '0); endtask
  task automatic add_rst(string nm); push(nm, 1'b0, 1'b1, zr(), 1'b0, '0); endtask

  task automatic seq_alu(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] alu);
    set_i(o, f3, f7);
    add({nm, ".fetch"}, 1, ftch(1));
    add({nm, ".decode"}, 1, dec());
    add({nm, ".exec"}, 1, ex(0,0,0,0,0,0,0,2,o[5] ? 2'd0 : 2'd1, alu));
    add({nm, ".aluwb"}, 1, ex(0,0,0,0,0,1,0,0,0,A_ADD));
  endtask

  task automatic seq_br(string nm, logic [2:0] f3, logic z, logic lts, logic ltu,
                        logic [3:0] alu, logic tk);
    set_i(7'b1100011, f3, 0);
    c_z = z; c_lts = lts; c_ltu = ltu;
    add({nm, ".fetch"}, 1, ftch(1));
    add({nm, ".decode"}, 1, dec());
    add({nm, ".branch"}, 1, ex(0,0,0,0,tk,0,0,2,0,alu));
  endtask

  task automatic drive(vec_t v);
    @(posedge clk); #1;
    reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    Zero = v.z; LtS = v.lts; LtU = v.ltu; mem_ready = v.rdy;
    sbq.push_back(v);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    tbl.delete();
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mv = sbq.pop_front();
      checks++;
      if (oa === mv.e) passes++;
      else $display("FAIL %s: got %h want %h", mv.nm, oa, mv.e);
      if (mv.c2) begin
        checks++;
        if (ob === mv.e2) passes++;
        else $display("FAIL %s/fb0: got %h want %h", mv.nm, ob, mv.e2);
      end
    end
  end

  initial begin
    outs_t e2;
    reset = 1; op = 0; funct3 = 0; funct7b5 = 0; Zero = 0; LtS = 0; LtU = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    s_ill = 0; s_flt = 0;

    // ---- table of single-cycle vectors covering each instruction class ----
    set_i(7'b0110011, 3'b000, 0);
    add_rst("reset");
    seq_alu("add",  7'b0110011, 3'b000, 0, A_ADD);
    seq_alu("sub",  7'b0110011, 3'b000, 1, A_SUB);
    seq_alu("sra",  7'b0110011, 3'b101, 1, A_SRA);
    seq_alu("sltu", 7'b0110011, 3'b011, 0, A_SLTU);
    seq_alu("andi", 7'b0010011, 3'b111, 0, A_AND);
    seq_alu("addi_f7", 7'b0010011, 3'b000, 1, A_ADD);
    seq_alu("srai", 7'b0010011, 3'b101, 1, A_SRA);
    seq_alu("srli", 7'b0010011, 3'b101, 0, A_SRL);
    seq_alu("xori", 7'b0010011, 3'b100, 0, A_XOR);

    set_i(7'b0000011, 3'b010, 0);
    add("lw.fetch", 1, ftch(1));
    add("lw.decode", 1, dec());
    add("lw.memadr", 1, ex(0,0,0,0,0,0,0,2,1,A_ADD));
    for (int i = 0; i < 3; i++) add("lw.memread_wait", 0, ex(1,1,0,0,0,0,0,0,0,A_ADD));
    add("lw.memread_rdy", 1, ex(1,1,0,0,0,0,0,0,0,A_ADD));
    add("lw.memwb", 1, ex(0,0,0,0,0,1,1,0,0,A_ADD));

    set_i(7'b0100011, 3'b010, 0);
    add("sw.fetch_wait", 0, ftch(0));
    add("sw.fetch", 1, ftch(1));
    add("sw.decode", 1, dec());
    add("sw.memadr", 1, ex(0,0,0,0,0,0,0,2,1,A_ADD));
    add("sw.memwrite_wait", 0, ex(1,1,1,0,0,0,0,0,0,A_ADD));
    add("sw.memwrite_rdy", 1, ex(1,1,1,0,0,0,0,0,0,A_ADD));

    seq_br("bne_z0", 3'b001, 0, 0, 0, A_SUB, 1);
    seq_br("bne_z1", 3'b001, 1, 0, 0, A_SUB, 0);
    seq_br("beq_z1", 3'b000, 1, 0, 0, A_SUB, 1);
    seq_br("blt",    3'b100, 0, 1, 0, A_SLT, 1);
    seq_br("bge",    3'b101, 0, 1, 0, A_SLT, 0);
    seq_br("bltu",   3'b110, 0, 0, 1, A_SLTU, 1);
    seq_br("bgeu",   3'b111, 0, 0, 0, A_SLTU, 1);

    set_i(7'b1101111, 3'b000, 0);
    add("jal.fetch", 1, ftch(1)); add("jal.decode", 1, dec());
    add("jal.jal", 1, ex(0,0,0,0,1,0,0,1,2,A_ADD));
    add("jal.aluwb", 1, ex(0,0,0,0,0,1,0,0,0,A_ADD));
    set_i(7'b1100111, 3'b000, 0);
    add("jalr.fetch", 1, ftch(1)); add("jalr.decode", 1, dec());
    add("jalr.jalr", 1, ex(0,0,0,0,1,0,0,2,1,A_ADD));
    add("jalr.aluwb", 1, ex(0,0,0,0,0,1,0,0,0,A_ADD));
    set_i(7'b0110111, 3'b000, 0);
    add("lui.fetch", 1, ftch(1)); add("lui.decode", 1, dec());
    add("lui.lui", 1, ex(0,0,0,0,0,0,0,3,1,A_ADD));
    add("lui.aluwb", 1, ex(0,0,0,0,0,1,0,0,0,A_ADD));
    set_i(7'b0010111, 3'b000, 0);
    add("auipc.fetch", 1, ftch(1)); add("auipc.decode", 1, dec());
    add("auipc.lui", 1, ex(0,0,0,0,0,0,0,1,1,A_ADD));
    add("auipc.aluwb", 1, ex(0,0,0,0,0,1,0,0,0,A_ADD));

    set_i(7'b1110011, 3'b001, 0);
    add("sys.fetch", 1, ftch(1)); add("sys.decode", 1, dec());
`ifdef MC_CSR_EN
    add("sys.sys", 1, ex(0,0,0,0,0,1,2,0,0,A_ADD));
`else
    s_ill = 1;
    add("sys.halt", 1, zr());
    add_rst("sys.reset");
    s_ill = 0;
`endif

    set_i(7'b0000000, 3'b000, 0);
    add("ill.fetch", 1, ftch(1)); add("ill.decode", 1, dec());
    s_ill = 1;
    add("ill.halt", 1, zr());
    add("ill.halt_rdy_ignored", 1, zr());
    add_rst("ill.reset");
    s_ill = 0;
    add("ill.after_reset", 0, ftch(0));
    run_tbl();

    // ---- fetch timeout: 15 waiting cycles, then HALT with mem_fault ----
    set_i(7'b0110011, 3'b000, 0);
    add_rst("to.reset");
    for (int i = 0; i < 15; i++) add("to.fetch_wait", 0, ftch(0));
    s_flt = 1;
    add("to.halt", 1, zr());
    add("to.halt2", 1, zr());
    add_rst("to.reset2");
    s_flt = 0;
    run_tbl();

    // ---- reset in the middle of a store ----
    set_i(7'b0100011, 3'b010, 0);
    add("rw.fetch", 1, ftch(1)); add("rw.decode", 1, dec());
    add("rw.memadr", 1, ex(0,0,0,0,0,0,0,2,1,A_ADD));
    add("rw.memwrite", 0, ex(1,1,1,0,0,0,0,0,0,A_ADD));
    add_rst("rw.reset");
    add("rw.fetch_after", 0, ftch(0));
    add("rw.fetch2", 1, ftch(1));
    add("rw.decode2", 1, dec());
    add("rw.memadr2", 1, ex(0,0,0,0,0,0,0,2,1,A_ADD));
    // store that never completes: strobe dropped in the abandoning cycle
    for (int i = 0; i < 14; i++) add("wt.memwrite_wait", 0, ex(1,1,1,0,0,0,0,0,0,A_ADD));
    add("wt.memwrite_last", 0, ex(1,1,0,0,0,0,0,0,0,A_ADD));
    s_flt = 1;
    add("wt.halt", 1, zr());
    add_rst("wt.reset");
    s_flt = 0;
    run_tbl();

    // ---- FULL_BRANCH=0 instance: beq still works, bne is illegal ----
    set_i(7'b1100011, 3'b000, 0);
    c_z = 1;
    add_rst("fb.reset");
    add("fb.beq.fetch", 1, ftch(1));
    add("fb.beq.decode", 1, dec());
    push("fb.beq.branch", 1, 1'b0, ex(0,0,0,0,1,0,0,2,0,A_SUB), 1'b1,
         ex(0,0,0,0,1,0,0,2,0,A_SUB));
    set_i(7'b1100011, 3'b001, 0);
    add("fb.bne.fetch", 1, ftch(1));
    add("fb.bne.decode", 1, dec());
    add("fb.bne.branch", 1, ex(0,0,0,0,1,0,0,2,0,A_SUB));
    e2 = zr(); e2.ill = 1'b1;
    push("fb.bne.after", 0, 1'b0, ftch(0), 1'b1, e2);
    run_tbl();

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
